// File: rtl/dmem_store_buffer.sv
// ----------------------------------------------------------------------------
// dmem_store_buffer
//
// Posted-write buffer between the pipeline's data-memory port and the data
// RAM. Stores retire into a DEPTH-entry FIFO and drain to the RAM over a
// req/ack handshake. Loads either hit a buffered store (forwarding) or are
// sent to the RAM while the core is stalled. Every accepted load returns its
// data on core_rd_data exactly one cycle after acceptance, flagged by a
// one-cycle core_rd_valid pulse.
//
// Build option (macro STORE_FWD_EN):
//   defined   : youngest-match store-to-load forwarding; a load miss is sent
//               to the RAM ahead of pending drains (never preempting a drain
//               that is already in flight).
//   undefined : no address comparators; every load waits until the buffer is
//               empty and no drain is in flight, then reads the RAM.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-low reset
//   core_wr       in   store request (held while core_stall=1)
//   core_rd       in   load request (held while core_stall=1)
//   core_addr     in   load/store word address
//   core_wr_data  in   store data
//   core_rd_data  out  load data, valid with core_rd_valid
//   core_rd_valid out  one-cycle pulse for each accepted load
//   core_stall    out  combinational; core must hold its request
//   mem_req       out  RAM request (registered)
//   mem_we        out  1 = drain write, 0 = load read (registered)
//   mem_addr      out  RAM word address (registered)
//   mem_wdata     out  RAM write data (registered)
//   mem_ack       in   RAM completes the current request this cycle
//   mem_rdata     in   RAM read data, valid with mem_ack on reads
//   occupancy     out  number of buffered stores
// ----------------------------------------------------------------------------
module dmem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       core_wr,
  input  logic                       core_rd,
  input  logic [ADDR_W-1:0]          core_addr,
  input  logic [DATA_W-1:0]          core_wr_data,
  output logic [DATA_W-1:0]          core_rd_data,
  output logic                       core_rd_valid,
  output logic                       core_stall,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic full, empty, ld_req, ld_ack, ld_accept, enq, pop;
  logic load_miss, load_go;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  // A simultaneous store wins; the load is ignored that cycle.
  assign ld_req = core_rd & ~core_wr;
  assign ld_ack = (state_q == LOAD) & mem_ack;
  // Full-ness is judged before the edge, so a pop in the same cycle does not
  // open a slot for the store until the next cycle.
  assign enq    = core_wr & ~full;
  assign pop    = (state_q == DRAIN) & mem_ack;

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0]  match;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // An entry is live when its distance from head is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] age;
      assign age       = PTR_W'(gi) - head_q;
      assign match[gi] = (CNT_W'(age) < count_q) && (buf_addr_q[gi] == core_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[head_q + PTR_W'(i)]) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data_q[head_q + PTR_W'(i)];
      end
    end
  end

  assign load_miss = ld_req & ~fwd_hit;
  // A missing address is not in the buffer, so reading RAM first is safe.
  assign load_go   = load_miss;
`else
  assign load_miss = ld_req;
  // Without comparators the read must wait for every older store to land.
  assign load_go   = ld_req & empty;
`endif

  // A miss is released in the cycle its RAM read acknowledges.
  assign core_stall = (core_wr & full) | (load_miss & ~ld_ack);
  assign ld_accept  = ld_req & ~core_stall;

  always_comb begin
    rd_valid_d = ld_accept;
    rd_data_d  = rd_data_q;
    if (ld_accept) begin
`ifdef STORE_FWD_EN
      rd_data_d = ld_ack ? mem_rdata : fwd_data;
`else
      rd_data_d = mem_rdata;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (load_go) begin
          state_d    = LOAD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = core_addr;
        end else if (!empty) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = buf_addr_q[head_q];
          mem_wdata_d = buf_data_q[head_q];
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      LOAD: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; the count decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr_q[tail_q] <= core_addr;
      buf_data_q[tail_q] <= core_wr_data;
    end
  end

  assign core_rd_data  = rd_data_q;
  assign core_rd_valid = rd_valid_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign occupancy     = count_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk;
  logic              rst_n;
  logic              core_wr, core_rd;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_rd_valid, core_stall;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ack = 1'b0;
  logic [CNT_W-1:0]  occupancy;

  logic [DATA_W-1:0] ram [512];
  assign mem_rdata = ram[mem_addr];

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;
  int reads_seen = 0;

  logic [ADDR_W-1:0] exp_wr_addr [$];
  logic [DATA_W-1:0] exp_wr_data [$];
  logic [DATA_W-1:0] exp_ld [$];
  logic [ADDR_W:0]   op_log [$];
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;

  bit ack_en = 1'b0;
  int ack_delay = 0;
  int ack_cnt = 0;

  dmem_store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n),
    .core_wr(core_wr), .core_rd(core_rd), .core_addr(core_addr),
    .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
    .core_rd_valid(core_rd_valid), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM responder: acknowledges ack_delay cycles after the request rises.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !mem_req || !ack_en || mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (ack_cnt >= ack_delay) begin
      mem_ack = 1'b1;
    end else begin
      ack_cnt++;
    end
  end

  // Scoreboard: pops expected writes/loads as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_ack) begin
        op_log.push_back({mem_we, mem_addr});
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
          writes_seen++;
          $display("[%0t] RAM write addr=0x%03h data=0x%08h", $time, mem_addr, mem_wdata);
          checks++;
          if (exp_wr_addr.size() == 0) begin
            errors++;
            $display("FAIL ram_write: got addr=0x%03h data=0x%08h, expected no write", mem_addr, mem_wdata);
          end else begin
            mon_addr = exp_wr_addr.pop_front();
            mon_data = exp_wr_data.pop_front();
            if (mem_addr !== mon_addr || mem_wdata !== mon_data) begin
              errors++;
              $display("FAIL ram_write: got addr=0x%03h data=0x%08h, expected addr=0x%03h data=0x%08h",
                       mem_addr, mem_wdata, mon_addr, mon_data);
            end
          end
        end else begin
          reads_seen++;
          $display("[%0t] RAM read  addr=0x%03h data=0x%08h", $time, mem_addr, mem_rdata);
        end
      end
      if (core_rd_valid) begin
        $display("[%0t] load result data=0x%08h", $time, core_rd_data);
        checks++;
        if (exp_ld.size() == 0) begin
          errors++;
          $display("FAIL load_result: got 0x%08h, expected no load result", core_rd_data);
        end else begin
          mon_data = exp_ld.pop_front();
          if (core_rd_data !== mon_data) begin
            errors++;
            $display("FAIL load_result: got 0x%08h, expected 0x%08h", core_rd_data, mon_data);
          end
        end
      end
    end
  end

  // Drive one store from a posedge+1 point; returns at posedge+1 after accept.
  task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output bit stalled);
    stalled = 1'b0;
    core_wr = 1'b1;
    core_addr = a;
    core_wr_data = d;
    exp_wr_addr.push_back(a);
    exp_wr_data.push_back(d);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!core_stall) break;
      stalled = 1'b1;
      if (n == 199) begin
        checks++;
        errors++;
        $display("FAIL store_timeout: addr=0x%03h still stalled, expected acceptance", a);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    core_wr = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!(occupancy == 0 && !mem_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(occupancy == 0 && !mem_req)) begin
      errors++;
      $display("FAIL drain_timeout: occupancy=%0d mem_req=%0b, expected 0/0", occupancy, mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit st;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, core_rd_data, core_rd_valid, occupancy, core_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b we=%0b addr=0x%03h wdata=0x%08h rdata=0x%08h valid=%0b occ=%0d, expected all 0",
               mem_req, mem_we, mem_addr, mem_wdata, core_rd_data, core_rd_valid, occupancy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, occupancy, core_rd_valid, core_stall} !== '0) begin
        errors++;
        $display("FAIL idle_after_reset: req=%0b we=%0b occ=%0d valid=%0b stall=%0b, expected 0",
                 mem_req, mem_we, occupancy, core_rd_valid, core_stall);
      end
    end
    @(posedge clk); #1;
    do_store(9'h0AB, 32'h1234_5678, st);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h0AB) begin
      errors++;
      $display("FAIL drain_started: req=%0b we=%0b addr=0x%03h, expected 1/1/0x0ab", mem_req, mem_we, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || occupancy !== '0) begin
      errors++;
      $display("FAIL mid_drain_reset: req=%0b occ=%0d, expected 0/0", mem_req, occupancy);
    end
    exp_wr_addr.delete();
    exp_wr_data.delete();
    op_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_store();
    bit st;
    int base;
    @(negedge clk);
    ack_en = 1'b1;
    ack_delay = 2;
    @(posedge clk); #1;
    base = writes_seen;
    checks++;
    if (occupancy !== 0) begin
      errors++;
      $display("FAIL occ_before_store: got %0d, expected 0", occupancy);
    end
    do_store(9'h010, 32'h0000_01A5, st);
    checks++;
    if (st) begin
      errors++;
      $display("FAIL single_store_stall: core_stall=1 seen, expected never");
    end
    checks++;
    if (occupancy !== 1) begin
      errors++;
      $display("FAIL occ_after_store: got %0d, expected 1", occupancy);
    end
    wait_empty();
    checks++;
    if (writes_seen - base != 1 || exp_wr_addr.size() != 0) begin
      errors++;
      $display("FAIL single_write_count: got %0d writes (%0d pending), expected 1 (0)",
               writes_seen - base, exp_wr_addr.size());
    end
  endtask

  task automatic test_full_stall();
    bit st;
    bit any_st;
    @(negedge clk);
    ack_en = 1'b0;
    @(posedge clk); #1;
    any_st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(9'h020 + 9'(i), 32'h3000_0000 + 32'(i), st);
      any_st |= st;
    end
    checks++;
    if (any_st) begin
      errors++;
      $display("FAIL fill_stall: a store stalled, expected none of the first 4");
    end
    checks++;
    if (occupancy !== 4) begin
      errors++;
      $display("FAIL occ_full: got %0d, expected 4", occupancy);
    end
    core_wr = 1'b1;
    core_addr = 9'h024;
    core_wr_data = 32'h3000_0004;
    exp_wr_addr.push_back(9'h024);
    exp_wr_data.push_back(32'h3000_0004);
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin
      errors++;
      $display("FAIL full_stall: core_stall=%0b, expected 1", core_stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1 || occupancy !== 4 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: stall=%0b occ=%0d req=%0b, expected 1/4/1", core_stall, occupancy, mem_req);
    end
    ack_delay = 0;
    ack_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_ack !== 1'b1 || core_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_in_ack_cycle: ack=%0b stall=%0b, expected 1/1", mem_ack, core_stall);
    end
    ack_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b0 || occupancy !== 3) begin
      errors++;
      $display("FAIL accept_after_pop: stall=%0b occ=%0d, expected 0/3", core_stall, occupancy);
    end
    @(posedge clk); #1;
    core_wr = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 4) begin
      errors++;
      $display("FAIL occ_after_refill: got %0d, expected 4", occupancy);
    end
    ack_en = 1'b1;
    ack_delay = 1;
    @(posedge clk); #1;
    wait_empty();
    checks++;
    if (exp_wr_addr.size() != 0) begin
      errors++;
      $display("FAIL full_drain_all: %0d writes still pending, expected 0", exp_wr_addr.size());
    end
  endtask

`ifdef STORE_FWD_EN
  task automatic test_forward();
    bit st;
    int base;
    @(negedge clk);
    ack_en = 1'b0;
    @(posedge clk); #1;
    do_store(9'h003, 32'h0000_0011, st);
    do_store(9'h003, 32'h0000_0022, st);
    base = reads_seen;
    core_rd = 1'b1;
    core_addr = 9'h003;
    exp_ld.push_back(32'h0000_0022);
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b0) begin
      errors++;
      $display("FAIL fwd_stall: core_stall=%0b, expected 0", core_stall);
    end
    @(posedge clk); #1;
    core_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rd_valid !== 1'b1 || core_rd_data !== 32'h0000_0022) begin
      errors++;
      $display("FAIL fwd_data: valid=%0b data=0x%08h, expected 1/0x00000022", core_rd_valid, core_rd_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (core_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL fwd_pulse: valid=%0b, expected 0", core_rd_valid);
    end
    checks++;
    if (reads_seen != base) begin
      errors++;
      $display("FAIL fwd_no_ram_read: got %0d RAM reads, expected 0", reads_seen - base);
    end
    ack_en = 1'b1;
    ack_delay = 1;
    @(posedge clk); #1;
    wait_empty();
    checks++;
    if (exp_wr_addr.size() != 0 || exp_ld.size() != 0) begin
      errors++;
      $display("FAIL fwd_drain: %0d writes/%0d loads pending, expected 0/0", exp_wr_addr.size(), exp_ld.size());
    end
  endtask

  task automatic test_miss_priority();
    bit st;
    int n;
    @(negedge clk);
    ack_en = 1'b0;
    @(posedge clk); #1;
    op_log.delete();
    ram[9'h100] = 32'h0000_DEAD;
    do_store(9'h004, 32'h0000_00A4, st);
    do_store(9'h005, 32'h0000_00A5, st);
    core_rd = 1'b1;
    core_addr = 9'h100;
    exp_ld.push_back(32'h0000_DEAD);
    @(negedge clk);
    checks++;
    if (core_stall !== 1'b1) begin
      errors++;
      $display("FAIL miss_stall: core_stall=%0b, expected 1", core_stall);
    end
    ack_en = 1'b1;
    ack_delay = 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end while (core_stall && n < 50);
    checks++;
    if (core_stall !== 1'b0 || mem_ack !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h100) begin
      errors++;
      $display("FAIL miss_ack: stall=%0b ack=%0b we=%0b addr=0x%03h, expected 0/1/0/0x100",
               core_stall, mem_ack, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    core_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rd_valid !== 1'b1 || core_rd_data !== 32'h0000_DEAD) begin
      errors++;
      $display("FAIL miss_data: valid=%0b data=0x%08h, expected 1/0x0000dead", core_rd_valid, core_rd_data);
    end
    @(posedge clk); #1;
    wait_empty();
    checks++;
    if (op_log.size() != 3 || op_log[0] !== {1'b1, 9'h004} || op_log[1] !== {1'b0, 9'h100}
        || op_log[2] !== {1'b1, 9'h005}) begin
      errors++;
      $display("FAIL miss_order: got %0d ops, expected write 0x004, read 0x100, write 0x005", op_log.size());
    end
  endtask
`else
  task automatic test_load_after_store();
    bit st;
    int n;
    int base;
    @(negedge clk);
    ack_en = 1'b0;
    @(posedge clk); #1;
    op_log.delete();
    do_store(9'h008, 32'h0000_0077, st);
    base = reads_seen;
    core_rd = 1'b1;
    core_addr = 9'h008;
    exp_ld.push_back(32'h0000_0077);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (core_stall !== 1'b1) begin
        errors++;
        $display("FAIL nofwd_stall: cycle %0d core_stall=%0b, expected 1", i, core_stall);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (reads_seen != base || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL nofwd_read_early: reads=%0d we=%0b, expected 0 reads while drain pending",
               reads_seen - base, mem_we);
    end
    ack_en = 1'b1;
    ack_delay = 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end while (core_stall && n < 50);
    checks++;
    if (core_stall !== 1'b0 || mem_ack !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h008) begin
      errors++;
      $display("FAIL nofwd_ack: stall=%0b ack=%0b we=%0b addr=0x%03h, expected 0/1/0/0x008",
               core_stall, mem_ack, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    core_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rd_valid !== 1'b1 || core_rd_data !== 32'h0000_0077) begin
      errors++;
      $display("FAIL nofwd_data: valid=%0b data=0x%08h, expected 1/0x00000077", core_rd_valid, core_rd_data);
    end
    @(posedge clk); #1;
    wait_empty();
    checks++;
    if (op_log.size() != 2 || op_log[0] !== {1'b1, 9'h008} || op_log[1] !== {1'b0, 9'h008}) begin
      errors++;
      $display("FAIL nofwd_order: got %0d ops, expected write 0x008 then read 0x008", op_log.size());
    end
  endtask
`endif

  initial begin
    core_wr = 1'b0;
    core_rd = 1'b0;
    core_addr = '0;
    core_wr_data = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    test_reset();
    test_single_store();
    test_full_stall();
`ifdef STORE_FWD_EN
    test_forward();
    test_miss_priority();
`else
    test_load_after_store();
`endif
    checks++;
    if (exp_wr_addr.size() != 0 || exp_ld.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d writes/%0d loads never produced, expected 0/0", exp_wr_addr.size(), exp_ld.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
